// File: rtl/data_memory_responder.sv
// Byte-addressed word memory with a fixed-latency request/response handshake.
// A write+read pair is serviced write-first; the read is queued as one pending entry.
module data_memory_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read,
    input  logic [31:0] read_address,
    input  logic [3:0]  write,
    input  logic [31:0] write_address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        error
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam state_t START = (WAIT_STATES == 0) ? RESP : WAIT;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        load_req, load_pend;

    logic        op_wr;
    logic [31:0] op_addr;
    logic [3:0]  op_strb;
    logic [31:0] op_data;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] data_q;

    logic [31:0] mem [MEM_WORDS];

    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic          oor;
    logic [7:0]    strb_sh;
    logic [31:0]   data_sh;
    logic          wr_err;
    logic          resp_err;
    logic [31:0]   resp_data;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        load_req  = 1'b0;
        load_pend = 1'b0;
        case (state)
            IDLE: begin
                if (write != 4'b0 || read) begin
                    load_req = 1'b1;
                    cnt_nx   = 4'd0;
                    state_nx = START;
                end
            end
            WAIT: begin
                if (cnt == WS_LAST) state_nx = RESP;
                else                cnt_nx   = cnt + 4'd1;
            end
            RESP: begin
                if (pend) begin
                    load_pend = 1'b1;
                    cnt_nx    = 4'd0;
                    state_nx  = START;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pend      <= 1'b0;
            pend_addr <= 32'd0;
            op_wr     <= 1'b0;
            op_addr   <= 32'd0;
            op_strb   <= 4'd0;
            op_data   <= 32'd0;
            data_q    <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load_req) begin
                if (write != 4'b0) begin
                    op_wr     <= 1'b1;
                    op_addr   <= write_address;
                    op_strb   <= write;
                    op_data   <= data_in;
                    pend      <= read;
                    pend_addr <= read_address;
                end else begin
                    op_wr   <= 1'b0;
                    op_addr <= read_address;
                end
            end
            if (load_pend) begin
                op_wr   <= 1'b0;
                op_addr <= pend_addr;
                pend    <= 1'b0;
            end
            if (state == RESP) data_q <= resp_data;
        end
    end

    // A write faults whenever the offset pushes a strobed byte past the word boundary.
    always_comb begin
        off       = op_addr[1:0];
        idx       = op_addr[AW+1:2];
        oor       = |op_addr[31:AW+2];
        strb_sh   = {4'b0, op_strb} << off;
        data_sh   = op_data << {off, 3'b000};
        wr_err    = oor | (|strb_sh[7:4]);
        resp_err  = op_wr ? wr_err : oor;
        resp_data = (op_wr || oor) ? 32'd0 : (mem[idx] >> {off, 3'b000});
    end

    // Commit happens only in RESP, so a reset during WAIT drops the write.
    always_ff @(posedge clk) begin
        if (state == RESP && op_wr && !wr_err) begin
            for (int b = 0; b < 4; b++)
                if (strb_sh[b]) mem[idx][8*b +: 8] <= data_sh[8*b +: 8];
        end
    end

    assign ready    = (state == RESP);
    assign error    = ready & resp_err;
    assign data_out = ready ? resp_data : data_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized scoreboard bench for data_memory_responder against an array-based memory model.
module tb_data_memory_responder;

    localparam int MW = 1024;
    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        read = 1'b0;
    logic [31:0] read_address = 32'd0;
    logic [3:0]  write = 4'd0;
    logic [31:0] write_address = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        ready;
    logic        error;

    data_memory_responder #(.MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n), .read(read), .read_address(read_address),
        .write(write), .write_address(write_address), .data_in(data_in),
        .data_out(data_out), .ready(ready), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [MW];
    int          errors = 0;
    int          checks = 0;
    int          ecnt = 0;
    int          resp_cnt = 0;
    int          tmo_cnt = 0;
    int          tmo_seen = 0;
    bit          done = 1'b0;
    bit          reported = 1'b0;

    initial forever begin
        @(posedge clk);
        ecnt++;
    end

    // Monitor: sole owner of the error/check counters.
    initial begin
        logic [31:0] last_data;
        exp_t e;
        last_data = 32'd0;
        forever begin
            @(negedge clk);
            if (tmo_cnt != tmo_seen) begin
                checks++; errors++;
                $display("FAIL response_timeout: got %0d responses missing, want 0", tmo_cnt - tmo_seen);
                tmo_seen = tmo_cnt;
            end
            if (!reset_n) begin
                checks += 2;
                if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
                if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 00000000", data_out); end
                last_data = 32'd0;
            end else if (ready === 1'b1) begin
                resp_cnt++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: got ready=1 at edge %0d want no response", ecnt);
                end else begin
                    e = q.pop_front();
                    checks += 3;
                    if (data_out !== e.data) begin errors++; $display("FAIL resp_data: got %h want %h", data_out, e.data); end
                    if (error !== e.err) begin errors++; $display("FAIL resp_error: got %b want %b", error, e.err); end
                    if (ecnt != e.t) begin errors++; $display("FAIL resp_latency: got edge %0d want edge %0d", ecnt, e.t); end
                    last_data = e.data;
                end
            end else begin
                checks++;
                if (data_out !== last_data) begin errors++; $display("FAIL data_hold: got %h want %h", data_out, last_data); end
            end
            if (done && !reported) begin
                checks++;
                if (q.size() != 0) begin errors++; $display("FAIL leftover_responses: got %0d want 0", q.size()); end
                reported = 1'b1;
            end
        end
    end

    task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output exp_t e);
        int off;
        bit bad;
        off = int'(a % 4);
        bad = (a >= 4 * MW) || (s == 4'b0011 && off == 3) || (s == 4'b1111 && off != 0);
        if (!bad)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[(a / 4) % MW][8*(b+off) +: 8] = d[8*b +: 8];
        e.data = 32'd0;
        e.err  = bad;
        e.t    = 0;
    endtask

    task automatic model_read(input logic [31:0] a, output exp_t e);
        bit bad;
        bad    = (a >= 4 * MW);
        e.err  = bad;
        e.data = bad ? 32'd0 : (mdl[(a / 4) % MW] >> (8 * (a % 4)));
        e.t    = 0;
    endtask

    task automatic issue(input bit rd, input logic [31:0] ra, input logic [3:0] st,
                         input logic [31:0] wa, input logic [31:0] wd);
        exp_t e;
        int t, n, target;
        @(negedge clk); #1;
        read = rd; read_address = ra; write = st; write_address = wa; data_in = wd;
        t = ecnt + 1 + WS;
        n = 0;
        if (st != 4'd0) begin
            model_write(wa, st, wd, e); e.t = t; q.push_back(e); n++;
            t += 1 + WS;
        end
        if (rd) begin
            model_read(ra, e); e.t = t; q.push_back(e); n++;
        end
        target = resp_cnt + n;
        for (int i = 0; i < 40 && resp_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        if (resp_cnt < target) tmo_cnt += target - resp_cnt;
        read = 1'b0; write = 4'd0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'h1000 + $urandom_range(0, 255);
        if (r == 1) return $urandom;
        return 32'($urandom_range(0, 255));
    endfunction

    function automatic logic [3:0] rand_strb();
        case ($urandom_range(0, 2))
            0:       return 4'b0001;
            1:       return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        for (int w = 0; w < 64; w++) issue(1'b0, 32'd0, 4'hF, 32'(w * 4), $urandom);

        issue(1'b0, 32'd0, 4'hF, 32'h10, 32'hDEADBEEF);
        issue(1'b1, 32'h10, 4'h0, 32'd0, 32'd0);
        issue(1'b0, 32'd0, 4'hF, 32'h10, 32'h11223344);
        issue(1'b0, 32'd0, 4'b0001, 32'h13, 32'h000000AA);
        issue(1'b1, 32'h10, 4'h0, 32'd0, 32'd0);
        issue(1'b1, 32'h12, 4'h0, 32'd0, 32'd0);
        issue(1'b0, 32'd0, 4'b0011, 32'h13, 32'h0000BEEF);
        issue(1'b1, 32'h10, 4'h0, 32'd0, 32'd0);
        issue(1'b1, 32'h20, 4'hF, 32'h20, 32'h00000005);
        issue(1'b1, 32'h1000, 4'h0, 32'd0, 32'd0);
        issue(1'b0, 32'd0, 4'hF, 32'h1000, 32'hCAFEF00D);
        issue(1'b0, 32'd0, 4'hF, 32'h16, 32'h01020304);
        issue(1'b1, 32'h17, 4'h0, 32'd0, 32'd0);

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            issue(kind != 1, rand_addr(), (kind == 0) ? 4'd0 : rand_strb(), rand_addr(), $urandom);
        end

        // Reset in the middle of WAIT: no response, target word keeps its old value.
        @(negedge clk); #1;
        write = 4'hF; write_address = 32'h30; data_in = 32'h12345678;
        @(negedge clk); #1;
        reset_n = 1'b0; write = 4'd0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        issue(1'b1, 32'h30, 4'h0, 32'd0, 32'd0);
        issue(1'b1, 32'h30, 4'hF, 32'h30, 32'h0BADC0DE);

        repeat (3) @(negedge clk);
        #1 done = 1'b1;
        for (int i = 0; i < 10 && !reported; i++) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
